card_dealer: RTL and testbench

Upstream card source for the blackjack game FSM. The block holds a 52-card deck in a flop array, builds and Fisher-Yates shuffles it with an on-chip LFSR, and then deals one card per request. The game FSM pulls cards through a one-cycle request/valid handshake. Each card is delivered as the 8-bit code the FSM consumes on its card input.

---
 rtl/blackjack_pkg.sv | 58 +++++
 rtl/card_lfsr.sv | 37 +++
 rtl/card_dealer.sv | 159 +++++++++++++++
 tb/tb_card_dealer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: deck geometry, 8-bit card encoding,
// LFSR constants and the card dealer state enum.
package blackjack_pkg;

  // Deck geometry
  localparam int DECK_SIZE = 52;
  localparam int NUM_SUITS = 4;
  localparam int RANK_W    = 4;
  localparam int SUIT_W    = $clog2(NUM_SUITS);
  localparam int IDX_W     = 6;
  localparam int CARD_W    = 8;

  localparam logic [RANK_W-1:0] RANK_MIN = 4'd1;
  localparam logic [RANK_W-1:0] RANK_MAX = 4'd13;

  // Card code field positions: {2'b00, suit[5:4], rank[3:0]}
  localparam int RANK_LSB = 0;
  localparam int SUIT_LSB = 4;

  // LFSR constants
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef logic [IDX_W-1:0] deck_idx_t;

  // One deck entry as stored in the dealer's flop array
  typedef struct packed {
    logic [SUIT_W-1:0] suit;
    logic [RANK_W-1:0] rank;
  } card_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    READY
  } dealer_state_e;

  // Smallest all-ones value that covers idx (valid for idx >= 1):
  // smear the highest set bit into every lower position.
  function automatic deck_idx_t shuffle_mask(input deck_idx_t idx);
    deck_idx_t m;
    m = idx | (idx >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  // Pack a stored deck entry into the 8-bit code the game FSM consumes
  function automatic logic [CARD_W-1:0] card_code(input card_t c);
    logic [CARD_W-1:0] code;
    code = '0;
    code[SUIT_LSB +: SUIT_W] = c.suit;
    code[RANK_LSB +: RANK_W] = c.rank;
    return code;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR used as the shuffle entropy source. It runs freely
// every cycle, can be reseeded at any time, and never enters the all-zero
// lock-up state because a zero seed is replaced by the default seed.
module card_lfsr
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] next_value;

  // Next LFSR value: a load takes priority over the free-running shift
  always_comb begin
    // NOTE: assign a default before any conditional override so every path
    // drives next_value and no latch is inferred.
    next_value = {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    if (load) begin
      next_value = (seed == 16'h0000) ? SEED : seed;
    end
  end

  // LFSR register, returns to the seed on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: builds a 52-card deck in a flop array, Fisher-Yates shuffles
// it with LFSR-driven rejection sampling, then deals one card per request
// through a one-cycle request/valid handshake.
module card_dealer #(
  parameter int          DECK_SIZE = blackjack_pkg::DECK_SIZE,
  parameter logic [15:0] LFSR_SEED = blackjack_pkg::LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        shuffle_start,
  output logic        busy,
  output logic        shuffle_done,
  input  logic        deal_req,
  output logic        card_valid,
  output logic [7:0]  card,
  output logic [5:0]  cards_left,
  output logic        deck_empty
);

  import blackjack_pkg::*;

  // The design is built for a single 52-card deck only.
  localparam deck_idx_t  LAST_IDX   = deck_idx_t'(DECK_SIZE - 1);
  localparam logic [5:0] FULL_COUNT = 6'(DECK_SIZE);

  dealer_state_e state, next_state;

  card_t       deck [DECK_SIZE];
  deck_idx_t   ptr;          // INIT write index, then deal pointer
  deck_idx_t   shuf_idx;     // Fisher-Yates position i
  logic [1:0]  suit_cnt;
  logic [3:0]  rank_cnt;

  logic [15:0] lfsr_value;
  logic [9:0]  lfsr_unused;  // upper bits only feed back inside the LFSR
  deck_idx_t   shuf_mask;
  deck_idx_t   cand;
  logic        swap_ok;

  logic        start_build;
  logic        init_write;
  logic        do_swap;
  logic        do_deal;

  card_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (seed_load),
    .seed  (seed),
    .value (lfsr_value)
  );

  assign lfsr_unused = lfsr_value[15:6];

  // Rejection sampling: draw a candidate in [0, mask] and accept if <= i
  always_comb begin
    shuf_mask = shuffle_mask(shuf_idx);
    cand      = lfsr_value[5:0] & shuf_mask;
    swap_ok   = (cand <= shuf_idx);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a shuffle request always wins over a deal in READY
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (shuffle_start)                 next_state = INIT;
      INIT:    if (ptr == LAST_IDX)               next_state = SHUFFLE;
      SHUFFLE: if (swap_ok && shuf_idx == 6'd1)   next_state = READY;
      READY:   if (shuffle_start)                 next_state = INIT;
      default:                                    next_state = IDLE;
    endcase
  end

  // Output and control decode, all from registered state
  always_comb begin
    busy        = (state == INIT) || (state == SHUFFLE);
    deck_empty  = !busy && (cards_left == 6'd0);
    start_build = ((state == IDLE) || (state == READY)) && shuffle_start;
    init_write  = (state == INIT);
    do_swap     = (state == SHUFFLE) && swap_ok;
    do_deal     = (state == READY) && !shuffle_start && deal_req &&
                  (cards_left != 6'd0);
  end

  // Counters, pointers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      shuf_idx     <= '0;
      suit_cnt     <= '0;
      rank_cnt     <= RANK_MIN;
      cards_left   <= '0;
      card         <= '0;
      card_valid   <= 1'b0;
      shuffle_done <= 1'b0;
    end else begin
      card_valid   <= 1'b0;
      shuffle_done <= 1'b0;
      if (start_build) begin
        // A reshuffle discards whatever was left in the deck
        ptr        <= '0;
        suit_cnt   <= '0;
        rank_cnt   <= RANK_MIN;
        cards_left <= '0;
      end else if (init_write) begin
        ptr <= ptr + 6'd1;
        if (rank_cnt == RANK_MAX) begin
          rank_cnt <= RANK_MIN;
          suit_cnt <= suit_cnt + 2'd1;
        end else begin
          rank_cnt <= rank_cnt + 4'd1;
        end
        if (ptr == LAST_IDX) begin
          shuf_idx <= LAST_IDX;
        end
      end else if (do_swap) begin
        shuf_idx <= shuf_idx - 6'd1;
        if (shuf_idx == 6'd1) begin
          cards_left   <= FULL_COUNT;
          ptr          <= '0;
          shuffle_done <= 1'b1;
        end
      end else if (do_deal) begin
        card       <= card_code(deck[ptr]);
        card_valid <= 1'b1;
        ptr        <= ptr + 6'd1;
        cards_left <= cards_left - 6'd1;
      end
    end
  end

  // Deck storage: sequential build in INIT, one swap per accepted draw
  // NOTE: the deck array is deliberately left without reset; every entry is
  // rewritten in INIT before any card can be dealt from it.
  always_ff @(posedge clk) begin
    if (init_write) begin
      deck[ptr] <= card_t'({suit_cnt, rank_cnt});
    end else if (do_swap) begin
      // NOTE: non-blocking assignments make both right-hand sides read the
      // pre-edge contents, which is what turns these two writes into a swap.
      deck[shuf_idx] <= deck[cand];
      deck[cand]     <= deck[shuf_idx];
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer. A behavioural model predicts every
// output cycle by cycle: it tracks the free-running LFSR, and when a shuffle
// starts it computes the whole Fisher-Yates result and its duration at once.
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [15:0] seed;
  logic        shuffle_start;
  logic        deal_req;
  logic        busy;
  logic        shuffle_done;
  logic        card_valid;
  logic [7:0]  card;
  logic [5:0]  cards_left;
  logic        deck_empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  card_dealer dut (
    .clk           (clk),
    .reset         (reset),
    .seed_load     (seed_load),
    .seed          (seed),
    .shuffle_start (shuffle_start),
    .busy          (busy),
    .shuffle_done  (shuffle_done),
    .deal_req      (deal_req),
    .card_valid    (card_valid),
    .card          (card),
    .cards_left    (cards_left),
    .deck_empty    (deck_empty)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int mask_for(input int i);
    int m = 1;
    while (m < i) m = 2 * m + 1;
    return m;
  endfunction

  int          m_deck [52];
  int          m_state;      // 0 idle, 1 building/shuffling, 2 ready
  int          m_count;      // edges left until shuffle_done
  int          m_ptr;
  int          m_left;
  logic [7:0]  m_card;
  bit          m_valid;
  bit          m_done;
  logic [15:0] m_lfsr;
  logic [15:0] m_nl;

  // l0 is the LFSR value right after the edge that accepts shuffle_start
  task automatic model_start(input logic [15:0] l0);
    logic [15:0] v;
    int i, c, tries, tmp;
    v = l0;
    for (int k = 0; k < 52; k++) m_deck[k] = ((k / 13) << 4) | (k % 13 + 1);
    for (int k = 0; k < 52; k++) v = lfsr_step(v);
    i = 51;
    tries = 0;
    while (i > 0 && tries < 10000) begin
      c = int'(v[5:0]) & mask_for(i);
      if (c <= i) begin
        tmp = m_deck[i]; m_deck[i] = m_deck[c]; m_deck[c] = tmp;
        i--;
      end
      v = lfsr_step(v);
      tries++;
    end
    m_count = 52 + tries;
    m_state = 1;
    m_left  = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_lfsr = 16'hACE1; m_ptr = 0; m_left = 0;
      m_card = 8'h00; m_valid = 0; m_done = 0; m_count = 0;
    end else begin
      m_nl = seed_load ? ((seed == 16'h0) ? 16'hACE1 : seed) : lfsr_step(m_lfsr);
      m_valid = 0;
      m_done  = 0;
      case (m_state)
        0: if (shuffle_start) model_start(m_nl);
        1: begin
          m_count--;
          if (m_count == 0) begin
            m_state = 2; m_left = 52; m_ptr = 0; m_done = 1;
          end
        end
        default: begin
          if (shuffle_start) model_start(m_nl);
          else if (deal_req && m_left > 0) begin
            m_card = 8'(m_deck[m_ptr]);
            m_valid = 1; m_ptr++; m_left--;
          end
        end
      endcase
      m_lfsr = m_nl;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin : compare
    check("busy",         32'(busy),         32'(m_state == 1));
    check("deck_empty",   32'(deck_empty),   32'(m_state != 1 && m_left == 0));
    check("shuffle_done", 32'(shuffle_done), 32'(m_done));
    check("card_valid",   32'(card_valid),   32'(m_valid));
    check("card",         32'(card),         32'(m_card));
    check("cards_left",   32'(cards_left),   32'(m_left));
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] dealt [52];
  logic [7:0] seq_a [52];
  logic [7:0] seq_b [52];

  task automatic run_shuffle(input bit do_seed, input logic [15:0] s);
    int n;
    if (do_seed) begin
      seed_load = 1'b1; seed = s;
      @(negedge clk);
      seed_load = 1'b0;
    end
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    check("busy after start", 32'(busy), 32'd1);
    n = 0;
    while (!shuffle_done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("shuffle_done seen", 32'(shuffle_done), 32'd1);
    check("busy falls with done", 32'(busy), 32'd0);
    check("shuffle length", 32'(n >= 103), 32'd1);
    check("full deck count", 32'(cards_left), 32'd52);
  endtask

  task automatic deal_all();
    bit seen [64];
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    deal_req = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      check("deal valid latency", 32'(card_valid), 32'd1);
      check("cards_left step", 32'(cards_left), 32'(51 - k));
      check("card top bits", 32'(card[7:6]), 32'd0);
      check("card rank range", 32'(card[3:0] >= 4'd1 && card[3:0] <= 4'd13), 32'd1);
      check("card distinct", 32'(seen[card[5:0]]), 32'd0);
      seen[card[5:0]] = 1'b1;
      dealt[k] = card;
    end
    @(negedge clk);
    check("empty no valid", 32'(card_valid), 32'd0);
    check("empty card holds", 32'(card), 32'(dealt[51]));
    check("empty deck_empty", 32'(deck_empty), 32'd1);
    check("empty cards_left", 32'(cards_left), 32'd0);
    deal_req = 1'b0;
  endtask

  initial begin : stimulus
    int diffs, n, dones, valids, after;
    reset = 1'b0; seed_load = 1'b0; seed = 16'h0;
    shuffle_start = 1'b0; deal_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset card_valid", 32'(card_valid), 32'd0);
    check("reset cards_left", 32'(cards_left), 32'd0);
    check("reset deck_empty", 32'(deck_empty), 32'd1);
    check("reset card", 32'(card), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Pin the model's building blocks with hand-computed values
    check("model lfsr step", 32'(lfsr_step(16'hACE1)), 32'hE270);
    check("model mask 51", 32'(mask_for(51)), 32'd63);
    check("model mask 2", 32'(mask_for(2)), 32'd3);

    // Deal in IDLE is ignored
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    check("idle deal ignored", 32'(card_valid), 32'd0);

    // Full deal and reproducibility with seed 1234
    run_shuffle(1'b1, 16'h1234);
    deal_all();
    seq_a = dealt;
    run_shuffle(1'b1, 16'h1234);
    deal_all();
    seq_b = dealt;
    diffs = 0;
    for (int k = 0; k < 52; k++) diffs += (seq_a[k] !== seq_b[k]) ? 1 : 0;
    check("repro seed 1234", 32'(diffs), 32'd0);

    // Zero seed behaves like the default seed
    run_shuffle(1'b1, 16'h0000);
    deal_all();
    seq_a = dealt;
    run_shuffle(1'b1, 16'hACE1);
    deal_all();
    seq_b = dealt;
    diffs = 0;
    for (int k = 0; k < 52; k++) diffs += (seq_a[k] !== seq_b[k]) ? 1 : 0;
    check("zero seed equals ACE1", 32'(diffs), 32'd0);

    // Busy lockout: deal and restart requests during SHUFFLE are ignored
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (55) @(negedge clk);
    check("lockout in shuffle", 32'(busy), 32'd1);
    deal_req = 1'b1; shuffle_start = 1'b1;
    dones = 0; valids = 0; after = 0; n = 0;
    while (n < 4000 && (dones == 0 || after < 20)) begin
      @(negedge clk);
      n++;
      if (n == 3) begin deal_req = 1'b0; shuffle_start = 1'b0; end
      if (shuffle_done) dones++;
      if (card_valid) valids++;
      if (dones > 0) after++;
    end
    check("lockout single done", 32'(dones), 32'd1);
    check("lockout no deals", 32'(valids), 32'd0);
    check("lockout deck full", 32'(cards_left), 32'd52);

    // Reset in the middle of SHUFFLE
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (70) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset deck_empty", 32'(deck_empty), 32'd1);
    check("midreset cards_left", 32'(cards_left), 32'd0);
    check("midreset card_valid", 32'(card_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    check("after reset no deal", 32'(card_valid), 32'd0);

    // Reshuffle from READY with 40 cards left; shuffle beats deal
    run_shuffle(1'b0, 16'h0000);
    deal_req = 1'b1;
    repeat (12) @(negedge clk);
    deal_req = 1'b0;
    check("forty left", 32'(cards_left), 32'd40);
    deal_req = 1'b1; shuffle_start = 1'b1;
    @(negedge clk);
    deal_req = 1'b0; shuffle_start = 1'b0;
    check("reshuffle no deal", 32'(card_valid), 32'd0);
    check("reshuffle discards", 32'(cards_left), 32'd0);
    check("reshuffle busy", 32'(busy), 32'd1);
    n = 0;
    while (!shuffle_done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reshuffle done", 32'(shuffle_done), 32'd1);
    check("reshuffle full deck", 32'(cards_left), 32'd52);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
